// File: rtl/led_fx_pwm.sv
// N-channel LED PWM driver with a small effect engine (static, fade, breathe, off).
// Effective duties are latched at the end of each PWM period, so duty changes never glitch mid-period.
module led_fx_pwm #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int CLK_HZ     = 27000000,
  parameter int STEP_HZ    = 200,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty_in,
  input  logic                         load,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CHANNELS*PWM_BITS-1:0] cur_duty,
  output logic                         step_tick,
  output logic                         busy
);
  // state   | meaning
  // STATIC  | eff = cur, cur follows load, cur <= target on entry
  // FADE    | cur steps 1 toward target on each step_tick
  // BREATHE | eff = cur scaled by triangle envelope, env restarts at 0 on entry
  // OFF     | eff = 0, cur holds, target still loads

  localparam int N   = PWM_BITS;
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [N-1:0]  ENV_MAX  = {N{1'b1}};
  localparam logic [N-1:0]  CNT_LAST = {{(N-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    M_STATIC  = 2'd0,
    M_FADE    = 2'd1,
    M_BREATHE = 2'd2,
    M_OFF     = 2'd3
  } mode_t;

  mode_t          mode_q, mode_d;
  logic [PW-1:0]  pre_cnt;
  logic [N-1:0]   pwm_cnt;
  logic [N-1:0]   env;
  logic           env_up;
  logic [N-1:0]   duty_ch [CHANNELS];
  logic [N-1:0]   target  [CHANNELS];
  logic [N-1:0]   cur     [CHANNELS];
  logic [N-1:0]   eff     [CHANNELS];
  logic [N-1:0]   eff_lat [CHANNELS];
  logic [2*N-1:0] env_scale;
  logic [2*N-1:0] prod    [CHANNELS];
  logic           period_end;
  logic           enter_static;
  logic           enter_breathe;

  assign step_tick     = (pre_cnt == PRE_LAST);
  assign period_end    = (pwm_cnt == CNT_LAST);
  assign enter_static  = (mode_d == M_STATIC) && (mode_q != M_STATIC);
  assign enter_breathe = (mode_d == M_BREATHE) && (mode_q != M_BREATHE);

  always_comb begin
    cur_duty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_ch[i]          = duty_in[i*N +: N];
      cur_duty[i*N +: N]  = cur[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= step_tick ? '0 : pre_cnt + PW'(1);
      pwm_cnt <= period_end ? '0 : pwm_cnt + N'(1);
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= M_STATIC;
    else      mode_q <= mode_d;
  end

  // Mode FSM: next state is simply the requested mode, one cycle later
  always_comb begin
    mode_d = mode_t'(mode);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        cur[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load) target[i] <= duty_ch[i];
        if (enter_static) begin
          cur[i] <= load ? duty_ch[i] : target[i];
        end else begin
          unique case (mode_q)
            M_STATIC, M_BREATHE: if (load) cur[i] <= duty_ch[i];
            M_FADE: begin
              // steps toward the target held before this edge
              if (step_tick) begin
                if (cur[i] < target[i])      cur[i] <= cur[i] + N'(1);
                else if (cur[i] > target[i]) cur[i] <= cur[i] - N'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env    <= '0;
      env_up <= 1'b1;
    end else if (enter_breathe) begin
      env    <= '0;
      env_up <= 1'b1;
    end else if (mode_q == M_BREATHE && step_tick) begin
      if (env_up) begin
        if (env == ENV_MAX) begin
          env_up <= 1'b0;
          env    <= CNT_LAST;
        end else begin
          env <= env + N'(1);
        end
      end else begin
        if (env == '0) begin
          env_up <= 1'b1;
          env    <= N'(1);
        end else begin
          env <= env - N'(1);
        end
      end
    end
  end

  // Mode FSM: outputs (effective duty per channel)
  always_comb begin
    env_scale = {{N{1'b0}}, env} + (2*N)'(1);
    for (int i = 0; i < CHANNELS; i++) begin
      prod[i] = {{N{1'b0}}, cur[i]} * env_scale;
      eff[i]  = '0;
      unique case (mode_q)
        M_STATIC, M_FADE: eff[i] = cur[i];
        M_BREATHE:        eff[i] = prod[i][2*N-1:N];
        default:          eff[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out <= {CHANNELS{ACTIVE_LOW}};
      for (int i = 0; i < CHANNELS; i++) eff_lat[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (pwm_cnt < eff_lat[i]) ^ ACTIVE_LOW;
        if (period_end) eff_lat[i] <= eff[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur[i] != target[i]) busy = 1'b1;
    end
    busy = busy && (mode_q == M_FADE);
  end

endmodule

// File: tb/tb_led_fx_pwm.sv
// Bench for led_fx_pwm (3 ch, 4-bit, DIV 10, period 15): directed scenarios plus random
// segments, all checked each cycle against a time-indexed behavioural model.
module tb_led_fx_pwm;
  localparam int CH  = 3;
  localparam int DIV = 10;
  localparam int PER = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [11:0] duty_in = '0;
  logic        load = 1'b0;
  logic [2:0]  pwm_out;
  logic [11:0] cur_duty;
  logic        step_tick;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: time since reset, mode, triangle phase, per-channel values
  int m_t, m_mode, m_phase;
  int m_tgt [CH];
  int m_cur [CH];
  int m_lat [CH];
  int m_on  [CH];

  led_fx_pwm #(
    .CHANNELS(3), .PWM_BITS(4), .CLK_HZ(100), .STEP_HZ(10), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .duty_in(duty_in), .load(load),
    .pwm_out(pwm_out), .cur_duty(cur_duty), .step_tick(step_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int env_of(input int ph);
    return (ph <= 15) ? ph : 30 - ph;
  endfunction

  function automatic int eff_of(input int i);
    case (m_mode)
      0, 1:    return m_cur[i];
      2:       return (m_cur[i] * (env_of(m_phase) + 1)) / 16;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_phase = 0;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0; m_cur[i] = 0; m_lat[i] = 0; m_on[i] = 0;
    end
  endtask

  task automatic model_check();
    logic [2:0]  e_out;
    logic [11:0] e_cur;
    logic        e_busy;
    e_busy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      e_out[i] = (m_on[i] != 0) ? 1'b0 : 1'b1;
      e_cur[i*4 +: 4] = 4'(m_cur[i]);
      if (m_mode == 1 && m_cur[i] != m_tgt[i]) e_busy = 1'b1;
    end
    chk("pwm_out", 32'(pwm_out), 32'(e_out));
    chk("cur_duty", 32'(cur_duty), 32'(e_cur));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("step_tick", 32'(step_tick), ((m_t % DIV) == DIV - 1) ? 32'd1 : 32'd0);
  endtask

  // one clock: model applies the spec rules to the inputs present at the edge
  task automatic step();
    int  cnt, d;
    bit  tick;
    int  eff_now [CH];
    @(posedge clk);
    cnt  = m_t % PER;
    tick = (m_t % DIV) == DIV - 1;
    for (int i = 0; i < CH; i++) begin
      eff_now[i] = eff_of(i);
      m_on[i]    = (cnt < m_lat[i]) ? 1 : 0;
    end
    if (cnt == PER - 1) for (int i = 0; i < CH; i++) m_lat[i] = eff_now[i];
    for (int i = 0; i < CH; i++) begin
      d = int'(duty_in[i*4 +: 4]);
      if (int'(mode) == 0 && m_mode != 0) m_cur[i] = load ? d : m_tgt[i];
      else if ((m_mode == 0 || m_mode == 2) && load) m_cur[i] = d;
      else if (m_mode == 1 && tick) begin
        if (m_cur[i] < m_tgt[i]) m_cur[i]++;
        else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
      end
      if (load) m_tgt[i] = d;
    end
    if (int'(mode) == 2 && m_mode != 2) m_phase = 0;
    else if (m_mode == 2 && tick) m_phase = (m_phase + 1) % 30;
    m_mode = int'(mode);
    m_t++;
    #1;
    model_check();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_pwm_out", 32'(pwm_out), 32'h7);
    chk("rst_cur_duty", 32'(cur_duty), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_step_tick", 32'(step_tick), 32'h0);
    model_reset();
    mode = 2'd0; load = 1'b0; duty_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic wait_cur0(input int exp_v, input string tag, output int n);
    int prev;
    n = 0;
    prev = int'(cur_duty[3:0]);
    while (int'(cur_duty[3:0]) == prev && n < 25) begin
      step();
      n++;
    end
    chk(tag, 32'(cur_duty[3:0]), 32'(exp_v));
  endtask

  initial begin
    int lo0, hi1, lo2, n, len;
    model_reset();
    #1 do_reset();

    // STATIC {15,0,5}
    duty_in = {4'd15, 4'd0, 4'd5}; load = 1'b1; step(); load = 1'b0;
    repeat (30) step();
    while (m_t % PER != 1) step();
    lo0 = 0; hi1 = 0; lo2 = 0;
    repeat (PER) begin
      step();
      lo0 += int'(!pwm_out[0]); hi1 += int'(pwm_out[1]); lo2 += int'(!pwm_out[2]);
    end
    chk("static_ch0_low_clks", 32'(lo0), 32'd5);
    chk("static_ch1_high_clks", 32'(hi1), 32'd15);
    chk("static_ch2_low_clks", 32'(lo2), 32'd15);

    // FADE 0 -> 3
    do_reset();
    mode = 2'd1; step();
    duty_in = 12'd3; load = 1'b1; step(); load = 1'b0;
    chk("fade_busy_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_cur0(k, $sformatf("fade_up_%0d", k), n);
      if (k > 1) chk($sformatf("fade_spacing_%0d", k), 32'(n), 32'd10);
    end
    chk("fade_busy_done", 32'(busy), 32'd0);

    // FADE with load coincident with step_tick
    do_reset();
    mode = 2'd1; step();
    duty_in = 12'd3; load = 1'b1; step(); load = 1'b0;
    wait_cur0(1, "coinc_pre1", n);
    wait_cur0(2, "coinc_pre2", n);
    n = 0;
    while (!step_tick && n < 20) begin step(); n++; end
    chk("coinc_tick_found", 32'(step_tick), 32'd1);
    duty_in = 12'd0; load = 1'b1; step(); load = 1'b0;
    chk("coinc_cur_old_target", 32'(cur_duty[3:0]), 32'd3);
    chk("coinc_busy", 32'(busy), 32'd1);
    wait_cur0(2, "coinc_down2", n);
    wait_cur0(1, "coinc_down1", n);
    wait_cur0(0, "coinc_down0", n);
    chk("coinc_busy_done", 32'(busy), 32'd0);

    // BREATHE on ch0 = 15, one full envelope cycle and a bit
    do_reset();
    duty_in = 12'd15; load = 1'b1; step(); load = 1'b0;
    mode = 2'd2;
    repeat (330) step();

    // OFF while fading, then resume
    do_reset();
    mode = 2'd1; step();
    duty_in = {4'd9, 4'd12, 4'd15}; load = 1'b1; step(); load = 1'b0;
    repeat (35) step();
    mode = 2'd3;
    repeat (60) step();
    chk("off_outputs_inactive", 32'(pwm_out), 32'h7);
    mode = 2'd1;
    repeat (80) step();

    // random segments
    for (int s = 0; s < 40; s++) begin
      mode = 2'($urandom_range(0, 3));
      len  = int'($urandom_range(20, 120));
      for (int c = 0; c < len; c++) begin
        load    = ($urandom_range(0, 7) == 0);
        duty_in = 12'($urandom);
        step();
      end
      load = 1'b0;
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
